// File: rtl/ifu_mem_ctrl_if.sv
// ifu_mem_ctrl_if: cache line-fill, prefetch request and external word-read
// signals of ifu_mem_ctrl. The controller uses the slave modport.
interface ifu_mem_ctrl_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH,
  parameter int LINE_WIDTH   = 128,
  parameter int WORD_WIDTH   = 32
);
  logic                  cache_reqTagValidIn;
  logic [TAG_WIDTH-1:0]  cache_reqTagIn;
  logic [TAG_WIDTH-1:0]  cache_rspTagOut;
  logic [LINE_WIDTH-1:0] cache_rspInsLineOut;
  logic                  cache_rspInsLineValidOut;
  logic                  pf_reqTagValidIn;
  logic [TAG_WIDTH-1:0]  pf_reqTagIn;
  logic                  pf_reqReadyOut;
  logic                  ext_rdReqOut;
  logic [ADDR_WIDTH-1:0] ext_rdAddrOut;
  logic                  ext_rdGntIn;
  logic [WORD_WIDTH-1:0] ext_rdDataIn;
  logic                  ext_rdDataValidIn;
  logic                  busyOut;

  modport slave (
    input  cache_reqTagValidIn, cache_reqTagIn,
    output cache_rspTagOut, cache_rspInsLineOut, cache_rspInsLineValidOut,
    input  pf_reqTagValidIn, pf_reqTagIn,
    output pf_reqReadyOut,
    output ext_rdReqOut, ext_rdAddrOut,
    input  ext_rdGntIn, ext_rdDataIn, ext_rdDataValidIn,
    output busyOut
  );

  modport master (
    output cache_reqTagValidIn, cache_reqTagIn,
    input  cache_rspTagOut, cache_rspInsLineOut, cache_rspInsLineValidOut,
    output pf_reqTagValidIn, pf_reqTagIn,
    input  pf_reqReadyOut,
    input  ext_rdReqOut, ext_rdAddrOut,
    output ext_rdGntIn, ext_rdDataIn, ext_rdDataValidIn,
    input  busyOut
  );
endinterface

// File: rtl/ifu_mem_ctrl.sv
// ifu_mem_ctrl: fetches instruction-cache lines word by word from the external
// read port for demand misses (priority) and queued prefetches, and returns
// each assembled line to the cache as a one-cycle pulse.
module ifu_mem_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH,
  parameter int LINE_WIDTH   = 128,
  parameter int WORD_WIDTH   = 32,
  parameter int BEATS        = LINE_WIDTH / WORD_WIDTH,
  parameter int PF_DEPTH     = 4
) (
  input logic           Clock,
  input logic           Rst,
  ifu_mem_ctrl_if.slave bus
);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                  state, stateNext;
  logic [TAG_WIDTH-1:0]    activeTag, demandTag;
  logic                    demandValid, justDone;
  logic [BEAT_W-1:0]       beat;
  logic [LINE_WIDTH-1:0]   lineBuf;
  logic [TAG_WIDTH-1:0]    pfQueue [PF_DEPTH];
  logic [PTR_W-1:0]        rdPtr, wrPtr;
  logic [CNT_W-1:0]        pfCount;
  logic [PF_DEPTH-1:0]     entryValid;
  logic [PTR_W-1:0]        rel;
  logic [OFFSET_WIDTH-1:0] beatOffset;
  logic [ADDR_WIDTH-1:0]   rdAddr;
  logic activeValid, capture, pfFull, pfDup, pfPush, lastBeat;
  logic dispatchDemand, dispatchPf, rdReq, rspValid;

  // The just-returned tag stays comparable for one cycle after RESP so a
  // level-held miss on it is not re-captured while the cache fills.
  assign activeValid = (state != IDLE) || justDone;
  assign capture     = bus.cache_reqTagValidIn
                     && !(activeValid && bus.cache_reqTagIn == activeTag)
                     && !(demandValid && bus.cache_reqTagIn == demandTag);
  assign pfFull      = (pfCount == CNT_W'(PF_DEPTH));
  assign pfPush      = bus.pf_reqTagValidIn && !pfFull && !pfDup;
  assign lastBeat    = (beat == BEAT_W'(BEATS - 1));
  assign beatOffset  = OFFSET_WIDTH'(int'(beat) * (WORD_WIDTH / 8));
  assign rdAddr      = {activeTag, beatOffset};

  assign bus.ext_rdReqOut             = rdReq;
  assign bus.ext_rdAddrOut            = rdAddr;
  assign bus.cache_rspInsLineValidOut = rspValid;
  assign bus.cache_rspTagOut          = activeTag;
  assign bus.cache_rspInsLineOut      = lineBuf;
  assign bus.pf_reqReadyOut           = !Rst && !pfFull;
  assign bus.busyOut                  = (state != IDLE);

  // Queue slot i holds a live entry when it lies within pfCount of the head.
  always_comb begin
    rel        = '0;
    entryValid = '0;
    for (int unsigned i = 0; i < PF_DEPTH; i++) begin
      rel           = PTR_W'(i) - rdPtr;
      entryValid[i] = ({1'b0, rel} < pfCount);
    end
  end

  // A prefetch is redundant if already active, pending, captured now or queued.
  always_comb begin
    pfDup = (activeValid && bus.pf_reqTagIn == activeTag)
         || (demandValid && bus.pf_reqTagIn == demandTag)
         || (capture && bus.pf_reqTagIn == bus.cache_reqTagIn);
    for (int unsigned i = 0; i < PF_DEPTH; i++) begin
      if (entryValid[i] && pfQueue[i] == bus.pf_reqTagIn) pfDup = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state, dispatch decisions and read/response strobes.
  always_comb begin
    stateNext      = state;
    dispatchDemand = 1'b0;
    dispatchPf     = 1'b0;
    rdReq          = 1'b0;
    rspValid       = 1'b0;
    case (state)
      IDLE: begin
        if (demandValid) begin
          dispatchDemand = 1'b1;
          stateNext      = REQ;
        end else if (pfCount != '0) begin
          dispatchPf = 1'b1;
          stateNext  = REQ;
        end
      end
      REQ: begin
        rdReq = 1'b1;
        if (bus.ext_rdGntIn) stateNext = WAIT;
      end
      WAIT: begin
        if (bus.ext_rdDataValidIn) stateNext = lastBeat ? RESP : REQ;
      end
      RESP: begin
        rspValid  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Active tag, demand register, beat counter and line assembly.
  // A capture in the same cycle as a demand dispatch re-arms the register,
  // so the new demand waits for the fetch just started.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      activeTag   <= '0;
      demandTag   <= '0;
      demandValid <= 1'b0;
      justDone    <= 1'b0;
      beat        <= '0;
      lineBuf     <= '0;
    end else begin
      justDone <= (state == RESP);
      if (dispatchDemand) begin
        activeTag <= demandTag;
        beat      <= '0;
      end else if (dispatchPf) begin
        activeTag <= pfQueue[rdPtr];
        beat      <= '0;
      end
      if (capture) begin
        demandValid <= 1'b1;
        demandTag   <= bus.cache_reqTagIn;
      end else if (dispatchDemand) begin
        demandValid <= 1'b0;
      end
      if (state == WAIT && bus.ext_rdDataValidIn) begin
        lineBuf[int'(beat) * WORD_WIDTH +: WORD_WIDTH] <= bus.ext_rdDataIn;
        if (!lastBeat) beat <= beat + BEAT_W'(1);
      end
    end
  end

  // Prefetch queue: circular buffer, push at tail, pop head on dispatch.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < PF_DEPTH; i++) pfQueue[i] <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      pfCount <= '0;
    end else begin
      if (pfPush) begin
        pfQueue[wrPtr] <= bus.pf_reqTagIn;
        wrPtr          <= wrPtr + PTR_W'(1);
      end
      if (dispatchPf) rdPtr <= rdPtr + PTR_W'(1);
      pfCount <= pfCount + CNT_W'(pfPush) - CNT_W'(dispatchPf);
    end
  end
endmodule

// File: doc/ifu_mem_ctrl.md
Name: ifu_mem_ctrl

Overview:
- Memory-side responder for the IFU instruction cache line-fill interface. Takes demand miss tags from the cache and prefetch tags from the prefetcher.
- Fetches each line from the word-wide external read port in BEATS sequential word reads, assembles the line, and returns it to the cache as a one-cycle tag+line+valid pulse.
- Sits between ifu_cache and the external instruction memory.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- OFFSET_WIDTH, 4, line offset bits.
- TAG_WIDTH, ADDR_WIDTH-OFFSET_WIDTH, line tag width.
- LINE_WIDTH, 128, line width in bits.
- WORD_WIDTH, 32, external read data width.
- BEATS, LINE_WIDTH/WORD_WIDTH, word reads per line.
- PF_DEPTH, 4, prefetch queue entries (power of 2).

Ports:
- Clock  in  1  clock
- Rst  in  1  asynchronous active-high reset
- cache_reqTagValidIn  in  1  level-held miss request from cache
- cache_reqTagIn  in  TAG_WIDTH  missed tag
- cache_rspTagOut  out  TAG_WIDTH  tag of returned line
- cache_rspInsLineOut  out  LINE_WIDTH  returned line
- cache_rspInsLineValidOut  out  1  one-cycle line-valid pulse
- pf_reqTagValidIn  in  1  prefetch request valid
- pf_reqTagIn  in  TAG_WIDTH  prefetch tag
- pf_reqReadyOut  out  1  prefetch queue not full
- ext_rdReqOut  out  1  external word read request
- ext_rdAddrOut  out  ADDR_WIDTH  external word byte address
- ext_rdGntIn  in  1  external accepts request this cycle
- ext_rdDataIn  in  WORD_WIDTH  read data
- ext_rdDataValidIn  in  1  read data valid
- busyOut  out  1  state != IDLE

Behaviour:
- Reset:
  - All outputs 0; pf_reqReadyOut = 1 once Rst deasserts.
  - State IDLE; demand register invalid; queue empty; beat counter 0.
  - Reset mid-fetch aborts immediately: ext_rdReqOut drops asynchronously and no response is issued.
- Active tag:
  - The tag being fetched.
  - Valid in REQ, WAIT and RESP states.
- Demand capture, on each edge:
  - Capture happens when cache_reqTagValidIn=1, the tag differs from the active tag (if any), and the tag differs from the held demand tag (if any).
  - The capture loads the demand register, overwriting any pending unstarted demand. This covers a redirect.
  - A demand equal to the active tag is not captured; the in-flight response satisfies it.
- Prefetch enqueue:
  - Enqueue occurs on pf_reqTagValidIn && pf_reqReadyOut.
  - The tag is dropped silently if it equals the active tag, the pending demand tag, the same-cycle captured demand tag, or any valid queue entry.
  - pf_reqReadyOut = !full. A full queue never overwrites.
- FSM:
  - IDLE:
    - If demand valid, set active = demand, clear demand, beat = 0, go to REQ.
    - Else if queue non-empty, pop the head into active and go to REQ.
    - Demand always has priority over prefetch.
  - REQ:
    - ext_rdReqOut = 1.
    - ext_rdAddrOut = {active tag, offset = beat*WORD_WIDTH/8}.
    - Hold until ext_rdGntIn = 1, then go to WAIT.
  - WAIT:
    - ext_rdReqOut = 0.
    - On ext_rdDataValidIn, store the word at line bits [beat*WORD_WIDTH +: WORD_WIDTH].
    - If beat == BEATS-1, go to RESP. Else beat++ and go to REQ.
    - ext_rdDataValidIn outside WAIT is ignored.
  - RESP:
    - cache_rspInsLineValidOut = 1 for exactly this cycle, with cache_rspTagOut = active tag and cache_rspInsLineOut = the assembled line.
    - Go to IDLE.
    - No backpressure: the cache always accepts.
- Only one word read is outstanding at a time. Words arrive in order.
- Latency:
  - Demand seen in cycle 0, with grant in the same cycle and data valid one cycle after grant.
  - The response pulse is in cycle 2 + 2*BEATS = cycle 10 for BEATS = 4.
- A level-held cache request during RESP and the following cycle carries the active (just-returned) tag and is not re-captured. The cache hits from the next cycle.
- Simultaneous demand capture and IDLE dispatch:
  - Dispatch uses the registered state.
  - The new demand is held and started after the current fetch.
- Beat counter width is clog2(BEATS), with a minimum of 1. Address offset arithmetic truncates to OFFSET_WIDTH.

Test Plan:
- Demand basic:
  - Stimulus: reqTag = 0x0000123 held; gnt = 1; data valid 1 cycle after grant with words 0xA0,0xA1,0xA2,0xA3.
  - Required: ext addrs 0x1230, 0x1234, 0x1238, 0x123C; one pulse in cycle 10 with line = 0x000000A3_000000A2_000000A1_000000A0 and tag = 0x123; no second fetch of 0x123.
- Grant stall:
  - Stimulus: gnt held low 5 cycles on beat 2.
  - Required: ext_rdAddrOut stable at 0x1238 with rdReq = 1 throughout; response delayed by exactly 5 cycles.
- Prefetch queue:
  - Stimulus: push tags 1, 2, 3, 4 and then 5.
  - Required: ready = 0 after 4 entries and tag 5 not accepted; duplicate push of tag 2 dropped; responses in order 1, 2, 3, 4.
- Demand priority:
  - Stimulus: demand 0x77 arrives while prefetch 1 is fetching and prefetches 2 and 3 are queued.
  - Required: response order 1, 0x77, 2, 3.
- Redirect and match:
  - Stimulus: demand 0x10 pending then changed to 0x20 before dispatch; later a demand equal to the active prefetch tag.
  - Required: only 0x20 fetched; the matching demand is not refetched and is served by the prefetch response.
- Reset mid-fetch:
  - Stimulus: Rst asserted in WAIT on beat 1.
  - Required: rdReq = 0, busy = 0, no rsp pulse; a subsequent demand fetches all 4 beats from offset 0.
